// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   pc_state_t         : state encoding of the program-counter sequencer FSM
//   DEFAULT_RESET_PC   : first fetch address after reset
//   DEFAULT_STEP       : byte increment between sequential fetches
//   BR_COUNT_W         : width of the optional taken-branch counter
//                        (enabled by PC_BRANCH_COUNT_EN)
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        FETCH      = 2'd1,
        WAIT_STALL = 2'd2,
        DRAIN      = 2'd3
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_STEP     = 4;
    localparam int          BR_COUNT_W       = 16;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Hold at all-ones so a long run of events never reads back as a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer sitting after the ALU. Issues instruction fetch
// addresses over a req/ack handshake, hands completed fetch PCs to decode,
// and redirects the fetch stream on taken branches (pulsing flush).
//
// Optional feature macro: PC_BRANCH_COUNT_EN adds a saturating 16-bit
// taken-branch counter on output br_count.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   br_valid   in   ALU result is a branch this cycle
//   change_pc  in   branch taken (only looked at with br_valid)
//   br_target  in   branch target (ALU op_0)
//   stall      in   decode back-pressure, blocks starting new fetches
//   imem_req   out  fetch request
//   imem_addr  out  fetch address, stable while a request is pending
//   imem_ack   in   memory completed the pending request this cycle
//   pc_out     out  address of the fetch just completed
//   pc_valid   out  one-cycle pulse, pc_out is valid
//   flush      out  one-cycle pulse on a taken branch
//   br_count   out  taken-branch count (PC_BRANCH_COUNT_EN only)
// -----------------------------------------------------------------------------
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
    parameter int              STEP     = DEFAULT_STEP
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  br_valid,
    input  logic                  change_pc,
    input  logic [PC_W-1:0]       br_target,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [PC_W-1:0]       imem_addr,
    input  logic                  imem_ack,
    output logic [PC_W-1:0]       pc_out,
    output logic                  pc_valid,
    output logic                  flush
`ifdef PC_BRANCH_COUNT_EN
    ,
    output logic [BR_COUNT_W-1:0] br_count
`endif
);

    // STEP is a power of two; targets are forced onto a STEP boundary.
    localparam logic [PC_W-1:0] STEP_V     = PC_W'(STEP);
    localparam logic [PC_W-1:0] ALIGN_MASK = ~(STEP_V - PC_W'(1));

    pc_state_t       state, state_n;
    logic [PC_W-1:0] next_pc, next_pc_n;
    logic [PC_W-1:0] req_addr, req_addr_n;
    logic [PC_W-1:0] pc_out_n;
    logic            pc_valid_n;
    logic            flush_n;
    logic            drop, drop_n;

    logic            taken;
    logic [PC_W-1:0] taken_target;

    assign taken        = br_valid & change_pc;
    assign taken_target = br_target & ALIGN_MASK;

    // A request is on the bus in FETCH and while draining an abandoned fetch.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = req_addr;

    // State and datapath registers; reset clears everything asynchronously so
    // an outstanding response is simply forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            next_pc  <= RESET_PC;
            req_addr <= RESET_PC;
            pc_out   <= '0;
            pc_valid <= 1'b0;
            flush    <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            next_pc  <= next_pc_n;
            req_addr <= req_addr_n;
            pc_out   <= pc_out_n;
            pc_valid <= pc_valid_n;
            flush    <= flush_n;
            drop     <= drop_n;
        end
    end

    // Next-state and next-output logic. next_pc always names the address of
    // the next fetch to issue; req_addr only moves when no request is
    // pending, so the bus address never changes under an unacknowledged
    // request.
    always_comb begin
        state_n    = state;
        next_pc_n  = next_pc;
        req_addr_n = req_addr;
        pc_out_n   = pc_out;
        pc_valid_n = 1'b0;
        flush_n    = taken;
        drop_n     = drop;

        unique case (state)
            BOOT: begin
                next_pc_n  = taken ? taken_target : next_pc;
                req_addr_n = next_pc_n;
                state_n    = stall ? WAIT_STALL : FETCH;
            end

            WAIT_STALL: begin
                // Nothing outstanding: a branch just replaces the next PC.
                next_pc_n  = taken ? taken_target : next_pc;
                req_addr_n = next_pc_n;
                if (!stall) begin
                    state_n = FETCH;
                end
            end

            FETCH: begin
                if (imem_ack) begin
                    if (taken) begin
                        // Response belongs to the wrong path: discard it.
                        next_pc_n = taken_target;
                    end else begin
                        next_pc_n = req_addr + STEP_V;
                        if (!drop) begin
                            pc_valid_n = 1'b1;
                            pc_out_n   = req_addr;
                        end
                    end
                    drop_n     = 1'b0;
                    req_addr_n = next_pc_n;
                    state_n    = stall ? WAIT_STALL : FETCH;
                end else if (taken) begin
                    // Request must stay on the bus until acked; remember to
                    // throw away its response.
                    next_pc_n = taken_target;
                    drop_n    = 1'b1;
                    state_n   = DRAIN;
                end
            end

            DRAIN: begin
                // Newest branch target wins if another arrives meanwhile.
                if (taken) begin
                    next_pc_n = taken_target;
                end
                if (imem_ack) begin
                    drop_n     = 1'b0;
                    req_addr_n = next_pc_n;
                    state_n    = stall ? WAIT_STALL : FETCH;
                end
            end

            default: begin
                state_n = BOOT;
            end
        endcase
    end

`ifdef PC_BRANCH_COUNT_EN
    // Count every taken branch the sequencer sees.
    sat_counter #(
        .W (BR_COUNT_W)
    ) u_br_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (taken),
        .count (br_count)
    );
`endif

endmodule : pc_sequencer
